// File: rtl/mpq_loader.sv
// rtl/mpq_loader.sv - streams a packed source-memory image into the MPQ data/command interface (optional MPQ_LOADER_CMDCHK_EN)
module mpq_loader #(
    parameter int DATA_NUM = 12,
    parameter int CMD_NUM  = 15,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_A,
    input  logic [7:0]        src_Q,
    output logic              data_valid,
    output logic [7:0]        data,
    output logic              cmd_valid,
    output logic [2:0]        cmd,
    output logic [7:0]        index,
    output logic [7:0]        value,
    input  logic              busy,
    input  logic              mpq_done,
    output logic              loading,
    output logic              finished
`ifdef MPQ_LOADER_CMDCHK_EN
    ,
    output logic [7:0]        bad_cmd_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HOLD,
        S_FIN
    } state_t;

    // Tag carried alongside each read so the returning byte lands in the right place.
    localparam logic [1:0] K_DATA = 2'd0;
    localparam logic [1:0] K_CMD  = 2'd1;
    localparam logic [1:0] K_IDX  = 2'd2;
    localparam logic [1:0] K_VAL  = 2'd3;

    localparam logic [ADDR_W-1:0] LP_DATA_END = ADDR_W'(DATA_NUM);
    localparam logic [4:0]        LP_CMD_LAST = 5'(CMD_NUM - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;      // next source address to read
    logic [4:0]        r_cmd_cnt;   // index of the record being handled
    logic [2:0]        r_fcnt;      // FETCH sub-step: 0..2 issue reads, 3..4 drain
    logic [1:0]        r_rd_kind;   // tag of the read currently on src_rd/src_A
    logic              r_q_vld;     // src_Q carries returned data this cycle
    logic [1:0]        r_q_kind;
    logic [2:0]        r_cmd_l;
    logic [7:0]        r_idx_l;
    logic [7:0]        r_val_l;
    logic              w_q_data;

    assign w_q_data = r_q_vld && (r_q_kind == K_DATA);

    // Read-return pipeline: register data bytes onto the MPQ bus and latch command fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q_vld    <= 1'b0;
            r_q_kind   <= K_DATA;
            data_valid <= 1'b0;
            data       <= 8'd0;
            r_cmd_l    <= 3'd0;
            r_idx_l    <= 8'd0;
            r_val_l    <= 8'd0;
        end else begin
            r_q_vld    <= src_rd;
            r_q_kind   <= r_rd_kind;
            data_valid <= w_q_data;
            data       <= w_q_data ? src_Q : 8'd0;
            if (r_q_vld) begin
                case (r_q_kind)
                    K_CMD:   r_cmd_l <= src_Q[2:0];
                    K_IDX:   r_idx_l <= src_Q;
                    K_VAL:   r_val_l <= src_Q;
                    default: ;
                endcase
            end
        end
    end

    // Control FSM: data stream, per-record fetch, busy handshake, command pulse and completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_cmd_cnt   <= 5'd0;
            r_fcnt      <= 3'd0;
            r_rd_kind   <= K_DATA;
            src_rd      <= 1'b0;
            src_A       <= '0;
            cmd_valid   <= 1'b0;
            cmd         <= 3'd0;
            index       <= 8'd0;
            value       <= 8'd0;
            loading     <= 1'b0;
            finished    <= 1'b0;
`ifdef MPQ_LOADER_CMDCHK_EN
            bad_cmd_cnt <= 8'd0;
`endif
        end else begin
            finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_DATA;
                        loading   <= 1'b1;
                        src_rd    <= 1'b1;
                        src_A     <= '0;
                        r_rd_kind <= K_DATA;
                        r_addr    <= ADDR_W'(1);
                        r_cmd_cnt <= 5'd0;
                        r_fcnt    <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (r_addr == LP_DATA_END) begin
                        src_rd  <= 1'b0;
                        r_fcnt  <= 3'd0;
                        r_state <= S_FETCH;
                    end else begin
                        src_rd <= 1'b1;
                        src_A  <= r_addr;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_fcnt < 3'd3) begin
                        src_rd    <= 1'b1;
                        src_A     <= r_addr;
                        r_addr    <= r_addr + 1'b1;
                        r_rd_kind <= r_fcnt[1:0] + 2'd1;
                        r_fcnt    <= r_fcnt + 3'd1;
                    end else if (r_fcnt == 3'd3) begin
                        src_rd <= 1'b0;
                        r_fcnt <= 3'd4;
                    end else begin
                        // Value byte lands on this edge; the cmd code is already latched.
                        r_fcnt <= 3'd0;
`ifdef MPQ_LOADER_CMDCHK_EN
                        if (r_cmd_l > 3'd4) begin
                            r_state <= S_HOLD;
                            if (bad_cmd_cnt != 8'hFF) begin
                                bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
`else
                        r_state <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    if (!busy) begin
                        cmd_valid <= 1'b1;
                        cmd       <= r_cmd_l;
                        index     <= r_idx_l;
                        value     <= r_val_l;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_valid <= 1'b0;
                    cmd       <= 3'd0;
                    index     <= 8'd0;
                    value     <= 8'd0;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_cmd_cnt == LP_CMD_LAST) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cmd_cnt <= r_cmd_cnt + 5'd1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FIN: begin
                    if (mpq_done) begin
                        finished <= 1'b1;
                        loading  <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
